// File: rtl/mem_axil_pkg.sv
// Shared types for mem_axil_bridge: FSM states, AXI response codes,
// the captured request record and the alignment helper.
package mem_axil_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_AR,
    S_RD,
    S_RESP
  } state_e;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // Field widths match the bridge's default parameters.
  localparam int REQ_ID_W   = 2;
  localparam int REQ_ADDR_W = 64;
  localparam int REQ_DATA_W = 64;

  typedef struct packed {
    logic [REQ_ID_W-1:0]     id;
    logic [REQ_ADDR_W-1:0]   addr;
    logic [REQ_DATA_W-1:0]   data;
    logic [REQ_DATA_W/8-1:0] be;
    logic [1:0]              size;
    logic                    we;
  } req_t;

  function automatic logic misaligned(
    input logic [2:0] addr_lo,
    input logic [1:0] size
  );
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return (addr_lo & mask) != 3'd0;
  endfunction

endpackage

// File: rtl/mem_axil_bridge.sv
// Arbiter request stream to single-outstanding AXI4-Lite bridge.
// Optional MEM_AXIL_BRIDGE_ALIGN_CHECK_EN rejects misaligned requests locally.
module mem_axil_bridge
  import mem_axil_pkg::*;
#(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   address_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [1:0]              size_i,
  input  logic [ID_WIDTH-1:0]     id_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [ID_WIDTH-1:0]     id_o,
  output logic                    err_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic [2:0]              m_awprot_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o,
  input  logic [1:0]              m_bresp_i,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic [2:0]              m_arprot_o,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]              m_rresp_i
);

  state_e state_q, state_d;
  req_t   req_q, req_d;

  logic                  aw_done_q, w_done_q;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  bad_align, resp_err;
  logic                  unused_ok;

  assign aw_hs = m_awvalid_o & m_awready_i;
  assign w_hs  = m_wvalid_o & m_wready_i;
  assign b_hs  = m_bvalid_i & m_bready_o;
  assign ar_hs = m_arvalid_o & m_arready_i;
  assign r_hs  = m_rvalid_i & m_rready_o;

`ifdef MEM_AXIL_BRIDGE_ALIGN_CHECK_EN
  assign bad_align = misaligned(address_i[2:0], size_i);
`else
  assign bad_align = 1'b0;
`endif

  assign resp_err = (resp_q == SLVERR) || (resp_q == DECERR);

  always_comb begin
    req_d                      = '0;
    req_d.id[ID_WIDTH-1:0]     = id_i;
    req_d.addr[ADDR_WIDTH-1:0] = address_i;
    req_d.data[DATA_WIDTH-1:0] = wdata_i;
    req_d.be[DATA_WIDTH/8-1:0] = be_i;
    req_d.size                 = size_i;
    req_d.we                   = we_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (bad_align) state_d = S_RESP;
          else           state_d = we_i ? S_WR : S_AR;
        end
      end
      S_WR: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs))
          state_d = S_WB;
      end
      S_WB:    if (b_hs)  state_d = S_RESP;
      S_AR:    if (ar_hs) state_d = S_RD;
      S_RD:    if (r_hs)  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, per-channel completion flags and response capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_q    <= OKAY;
      rdata_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_i) begin
            req_q     <= req_d;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= bad_align ? SLVERR : OKAY;
            rdata_q   <= '0;
          end
        end
        S_WR: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        S_WB: begin
          if (b_hs) resp_q <= m_bresp_i;
        end
        S_RD: begin
          if (r_hs) begin
            resp_q  <= m_rresp_i;
            rdata_q <= m_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_o       = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    rvalid_o    = 1'b0;
    err_o       = 1'b0;
    rdata_o     = '0;
    id_o        = '0;
    unique case (state_q)
      S_IDLE: gnt_o = req_i & ~rst_i;
      S_WR: begin
        m_awvalid_o = ~aw_done_q;
        m_wvalid_o  = ~w_done_q;
      end
      S_WB: m_bready_o  = 1'b1;
      S_AR: m_arvalid_o = 1'b1;
      S_RD: m_rready_o  = 1'b1;
      S_RESP: begin
        rvalid_o = 1'b1;
        err_o    = resp_err;
        id_o     = req_q.id[ID_WIDTH-1:0];
        if (!req_q.we && !resp_err) rdata_o = rdata_q;
      end
      default: ;
    endcase
  end

  assign m_awaddr_o = req_q.addr[ADDR_WIDTH-1:0];
  assign m_araddr_o = req_q.addr[ADDR_WIDTH-1:0];
  assign m_wdata_o  = req_q.data[DATA_WIDTH-1:0];
  assign m_wstrb_o  = req_q.be[DATA_WIDTH/8-1:0];
  assign m_awprot_o = 3'b000;
  assign m_arprot_o = 3'b000;

  assign unused_ok = ^{req_q.size};

endmodule
